ex_mem_stage_reg: RTL and testbench
===================================

# ex_mem_stage_reg

Parametrised EX/MEM pipeline stage register. It carries opcode, destination register, branch result and ALU result from execute to memory, and adds the following:
- valid/ready flow control, so a memory-side stall holds the stage without losing data;
- a synchronous flush for branch mispredicts;
- a forwarding tap for the hazard unit.

All state changes on the rising edge only; there is no split-edge capture.

## Interface
Parameters:
- OPCODE_W, 5, opcode field width
- RD_W, 7, destination-register field width
- BR_W, 7, branch-result field width
- DATA_W, 32, ALU result width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents a valid instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_opcode  in  OPCODE_W  opcode from EX
- in_rd  in  RD_W  destination register from EX
- in_branch  in  BR_W  branch result from EX
- in_alu  in  DATA_W  ALU result from EX
- flush  in  1  discard every held and incoming instruction
- out_valid  out  1  output fields hold a valid instruction
- out_ready  in  1  memory stage consumes the output this cycle
- out_opcode  out  OPCODE_W  registered opcode
- out_rd  out  RD_W  registered destination register
- out_branch  out  BR_W  registered branch result
- out_alu  out  DATA_W  registered ALU result
- fwd_valid  out  1  equals out_valid; head holds a result the hazard unit may forward
- fwd_rd  out  RD_W  equals out_rd
- fwd_data  out  DATA_W  equals out_alu

## Operation
Handshake rules:
- Input transfer occurs when in_valid and in_ready are both high on a rising edge.
- Output transfer occurs when out_valid and out_ready are both high on a rising edge.
- The head register drives all out_* and fwd_* ports.
- Output fields are stable while out_valid=1 and out_ready=0.

Head register:
- Loads when it is empty or being consumed, and new data is available.
- Source priority: the skid entry (if present), otherwise the input.

Flush:
- Clears head valid and skid valid on the next edge.
- An input arriving in the same cycle is dropped, even if in_ready=1.
- Flush has priority over every simultaneous transfer.
- Data fields are not cleared by flush; only the valid bits are.

Reset (rst_n=0, asynchronous):
- out_valid=0, fwd_valid=0, skid valid=0.
- All data outputs = 0.
- in_ready=1.

## Timing
- Latency: an input accepted at edge N appears on out_* after edge N, with out_valid=1 during cycle N+1.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready does not depend combinationally on out_ready when EXMEM_SKID_EN is defined (see Configuration).
- Back-to-back stall/release must neither duplicate nor drop an instruction. Order is strictly FIFO: head first, then skid.
- Reset deasserting mid-stream: the first edge after release can accept input. Nothing held before reset reappears.

## Configuration
EXMEM_SKID_EN.

Defined:
- Two entries: head plus skid.
- in_ready is a register and equals "skid empty".
- If the head is stalled (out_valid=1, out_ready=0) when an input transfer occurs, the input goes to skid. in_ready falls on the next edge.
- When the head is consumed, skid moves to head and in_ready rises on the next edge.
- Maximum occupancy is 2.

Not defined:
- Head register only; no skid storage.
- in_ready = !out_valid || out_ready, a combinational path from out_ready.
- Maximum occupancy is 1.

Both builds:
- Identical latency, ordering, flush and reset behaviour.

## Test plan
- Reset then stream: hold rst_n=0 for 3 cycles, then drive 4 consecutive inputs with in_alu=0x11,0x22,0x33,0x44 and out_ready=1. Required: out_valid first high one cycle after the first accept; out_alu shows 0x11..0x44 on consecutive cycles; in_ready stays 1 throughout.
- Stall with skid (EXMEM_SKID_EN): accept A (in_rd=5) and hold out_ready=0, then accept B (in_rd=9). Required: in_ready=0 after B, out_rd=5 held stable. Release out_ready for 2 cycles. Required: out_rd=5 then 9, and in_ready returns to 1.
- Stall without skid: same stimulus as the previous test. Required: B is not accepted while the head is stalled (in_ready=0 combinationally), and A is not overwritten.
- Flush with concurrent input: head valid and skid valid, then assert flush together with in_valid=1 and in_alu=0xDEAD. Required: out_valid=0 next cycle, 0xDEAD never appears on the output, in_ready=1.
- Asynchronous reset mid-stall: with 2 entries held, pulse rst_n low between edges. Required: out_valid=0 and out_alu=0 immediately without waiting for a clock edge, then normal acceptance on the first edge after release.
- Forward tap: accept an instruction with in_rd=0x12 and in_alu=0xCAFEF00D, holding out_ready=0. Required: fwd_valid=1, fwd_rd=0x12 and fwd_data=0xCAFEF00D for every stalled cycle.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline stage register with valid/ready flow control, flush and forwarding tap.
// Optional second (skid) entry enabled by defining EXMEM_SKID_EN.
module ex_mem_stage_reg #(
  parameter int OPCODE_W = 5,
  parameter int RD_W     = 7,
  parameter int BR_W     = 7,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [RD_W-1:0]     in_rd,
  input  logic [BR_W-1:0]     in_branch,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [RD_W-1:0]     out_rd,
  output logic [BR_W-1:0]     out_branch,
  output logic [DATA_W-1:0]   out_alu,
  output logic                fwd_valid,
  output logic [RD_W-1:0]     fwd_rd,
  output logic [DATA_W-1:0]   fwd_data
);

  localparam int PW = OPCODE_W + RD_W + BR_W + DATA_W;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] head_q, head_d;
  logic          head_vld_q, head_vld_d;
  logic          head_free;
  logic          in_xfer;

  assign in_pl     = {in_opcode, in_rd, in_branch, in_alu};
  assign head_free = !head_vld_q || out_ready;
  assign in_xfer   = in_valid && in_ready;

`ifdef EXMEM_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  logic          skid_vld_q, skid_vld_d;

  // in_ready comes straight from the skid valid flop, so it never sees out_ready
  assign in_ready = !skid_vld_q;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (head_free) begin
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        head_d     = in_pl;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = in_pl;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready = head_free;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    if (flush) begin
      head_vld_d = 1'b0;
    end else if (in_xfer) begin
      head_d     = in_pl;
      head_vld_d = 1'b1;
    end else if (out_ready) begin
      head_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  assign out_valid = head_vld_q;
  assign {out_opcode, out_rd, out_branch, out_alu} = head_q;

  assign fwd_valid = head_vld_q;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_alu;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench for ex_mem_stage_reg: directed scenarios with literal
// expectations plus randomized traffic checked against a queue model.
module tb_ex_mem_stage_reg;

  localparam int OPCODE_W = 5;
  localparam int RD_W     = 7;
  localparam int BR_W     = 7;
  localparam int DATA_W   = 32;
`ifdef EXMEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [OPCODE_W-1:0] in_opcode = '0;
  logic [RD_W-1:0]     in_rd = '0;
  logic [BR_W-1:0]     in_branch = '0;
  logic [DATA_W-1:0]   in_alu = '0;
  logic                flush = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [OPCODE_W-1:0] out_opcode;
  logic [RD_W-1:0]     out_rd;
  logic [BR_W-1:0]     out_branch;
  logic [DATA_W-1:0]   out_alu;
  logic                fwd_valid;
  logic [RD_W-1:0]     fwd_rd;
  logic [DATA_W-1:0]   fwd_data;

  ex_mem_stage_reg #(
    .OPCODE_W(OPCODE_W), .RD_W(RD_W), .BR_W(BR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_branch(in_branch), .in_alu(in_alu),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_branch(out_branch), .out_alu(out_alu),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OPCODE_W-1:0] op;
    logic [RD_W-1:0]     rd;
    logic [BR_W-1:0]     br;
    logic [DATA_W-1:0]   alu;
  } entry_t;

  entry_t q[$];
  bit     zero_data;
  int     checks = 0;
  int     errors = 0;
  bit     done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_ready();
    if (CAP == 2) return q.size() < 2;
    return q.size() == 0 || out_ready;
  endfunction

  // Reference model: an ordered queue of up to CAP instructions.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      zero_data = 1'b1;
    end else begin
      bit ix, ox;
      entry_t e;
      ix = in_valid && model_in_ready();
      ox = q.size() > 0 && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (ox) void'(q.pop_front());
        if (ix) begin
          e.op = in_opcode; e.rd = in_rd; e.br = in_branch; e.alu = in_alu;
          q.push_back(e);
          zero_data = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("m_in_ready", {63'd0, in_ready}, {63'd0, model_in_ready()});
      chk("m_out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("m_fwd_valid", {63'd0, fwd_valid}, {63'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("m_opcode", 64'(out_opcode), 64'(q[0].op));
        chk("m_rd", 64'(out_rd), 64'(q[0].rd));
        chk("m_branch", 64'(out_branch), 64'(q[0].br));
        chk("m_alu", 64'(out_alu), 64'(q[0].alu));
        chk("m_fwd_rd", 64'(fwd_rd), 64'(q[0].rd));
        chk("m_fwd_data", 64'(fwd_data), 64'(q[0].alu));
      end else if (zero_data) begin
        chk("m_zero_alu", 64'(out_alu), 64'd0);
        chk("m_zero_rd", 64'(out_rd), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] alu);
    in_valid = v; in_rd = rd; in_alu = alu;
    in_opcode = OPCODE_W'($urandom); in_branch = BR_W'($urandom);
  endtask

  initial begin
    bit seen_dead;
    // Reset, then a 4-deep stream with out_ready=1
    rst_n = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_alu", 64'(out_alu), 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, RD_W'(i), DATA_W'(32'h11 * (i + 1)));
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_alu", 64'(out_alu), 64'(32'h11 * (i + 1)));
    end
    drive(1'b0, '0, '0);
    step();
    chk("stream_drain", {63'd0, out_valid}, 64'd0);

    // Stall: A (rd=5) held, then B (rd=9) offered
    out_ready = 1'b0;
    drive(1'b1, 7'd5, 32'hA);
    step();
    drive(1'b1, 7'd9, 32'hB);
`ifdef EXMEM_SKID_EN
    chk("stall_accept_b", {63'd0, in_ready}, 64'd1);
    step();
    drive(1'b0, '0, '0);
    chk("stall_ready_low", {63'd0, in_ready}, 64'd0);
    chk("stall_rd_a", 64'(out_rd), 64'd5);
    step();
    chk("stall_rd_a_held", 64'(out_rd), 64'd5);
    out_ready = 1'b1;
    step();
    chk("release_rd_b", 64'(out_rd), 64'd9);
    chk("release_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("release_empty", {63'd0, out_valid}, 64'd0);
`else
    chk("stall_ready_low", {63'd0, in_ready}, 64'd0);
    step();
    chk("stall_rd_a", 64'(out_rd), 64'd5);
    chk("stall_alu_a", 64'(out_alu), 64'hA);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    #1;
    chk("release_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("release_empty", {63'd0, out_valid}, 64'd0);
`endif

    // Flush with concurrent input: stage full, then flush + 0xDEAD
    out_ready = 1'b0;
    for (int unsigned i = 0; i < CAP; i++) begin
      drive(1'b1, 7'h20, DATA_W'(32'h100 + i));
      step();
    end
    flush = 1'b1;
    drive(1'b1, 7'h21, 32'hDEAD);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    seen_dead = 1'b0;
    repeat (3) begin
      step();
      if (out_valid && out_alu == 32'hDEAD) seen_dead = 1'b1;
    end
    chk("flush_no_dead", {63'd0, seen_dead}, 64'd0);

    // Asynchronous reset mid-stall
    out_ready = 1'b0;
    for (int unsigned i = 0; i < CAP; i++) begin
      drive(1'b1, 7'h30, DATA_W'(32'h200 + i));
      step();
    end
    drive(1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_alu", 64'(out_alu), 64'd0);
    chk("arst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    #2 rst_n = 1'b1;
    drive(1'b1, 7'h31, 32'h300);
    step();
    drive(1'b0, '0, '0);
    chk("arst_accept", {63'd0, out_valid}, 64'd1);
    chk("arst_accept_alu", 64'(out_alu), 64'h300);

    // Forwarding tap during a stall
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drive(1'b1, 7'h12, 32'hCAFEF00D);
    step();
    drive(1'b0, '0, '0);
    repeat (3) begin
      chk("fwd_valid", {63'd0, fwd_valid}, 64'd1);
      chk("fwd_rd", 64'(fwd_rd), 64'h12);
      chk("fwd_data", 64'(fwd_data), 64'hCAFEF00D);
      step();
    end
    out_ready = 1'b1;
    step();

    // Randomized traffic checked by the model
    for (int unsigned i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_opcode = OPCODE_W'($urandom);
      in_rd     = RD_W'($urandom);
      in_branch = BR_W'($urandom);
      in_alu    = $urandom;
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
